// File: rtl/seg_scan_driver_if.sv
// Display-side bundle between the ALU test board logic and the scan driver.
interface seg_scan_driver_if;
  logic [31:0] data_in;
  logic [1:0]  flags_in;
  logic        load;
  logic        page_sel;
  logic        auto_page;
  logic        blank_lz;
  logic [3:0]  AN;
  logic [7:0]  dig;
  logic [1:0]  LED;
  logic        page_out;

  modport master (
    output data_in, flags_in, load, page_sel, auto_page, blank_lz,
    input  AN, dig, LED, page_out
  );

  modport slave (
    input  data_in, flags_in, load, page_sel, auto_page, blank_lz,
    output AN, dig, LED, page_out
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Registered 4-digit 7-segment scan driver for the ALU result word.
// Captures a 32-bit snapshot plus flags, then scans one 16-bit page at a time.
// The page is selected manually or toggled automatically every AUTO_PAGE_SCANS frames.
module seg_scan_driver #(
  parameter int SCAN_DIV        = 260000,
  parameter int AUTO_PAGE_SCANS = 256
) (
  input  logic             clock,
  input  logic             rst_n,
  seg_scan_driver_if.slave bus
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (AUTO_PAGE_SCANS > 1) ? $clog2(AUTO_PAGE_SCANS) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(AUTO_PAGE_SCANS - 1);

  logic [31:0]   snap_q, snap_d;
  logic [1:0]    flags_q, flags_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    idx_q, idx_d;
  logic          page_q, page_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    dig_q, dig_d;

  logic          tick;
  logic [2:0]    nib_sel;
  logic [3:0]    nib;
  logic          zero_hi;
  logic          blank;
  logic          dp_n;
  logic [7:0]    seg;

  // Active-low segment patterns {a..g,dp}; dp is left off here and patched in later.
  function automatic logic [7:0] seg7(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'h03;
      4'h1: s = 8'h9F;
      4'h2: s = 8'h25;
      4'h3: s = 8'h0D;
      4'h4: s = 8'h99;
      4'h5: s = 8'h49;
      4'h6: s = 8'h41;
      4'h7: s = 8'h1F;
      4'h8: s = 8'h01;
      4'h9: s = 8'h09;
      4'hA: s = 8'h11;
      4'hB: s = 8'hC1;
      4'hC: s = 8'h63;
      4'hD: s = 8'h85;
      4'hE: s = 8'h61;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  // Scan timing, digit index, paging and snapshot capture.
  always_comb begin
    tick    = (slot_q == SLOT_LAST);
    slot_d  = tick ? '0 : slot_q + 1'b1;
    idx_d   = tick ? idx_q + 1'b1 : idx_q;
    page_d  = page_q;
    frame_d = frame_q;
    snap_d  = bus.load ? bus.data_in : snap_q;
    flags_d = bus.load ? bus.flags_in : flags_q;
    if (!bus.auto_page) begin
      frame_d = '0;
      if (tick) page_d = bus.page_sel;
    end else if (tick && idx_q == 2'd3) begin
      // Count completed frames; page flips only at a frame boundary.
      if (frame_q == FRAME_LAST) begin
        page_d  = ~page_q;
        frame_d = '0;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  // Anode and segment pattern for the digit currently indexed.
  always_comb begin
    nib_sel = {page_q, idx_q};
    nib     = snap_q[{nib_sel, 2'b00} +: 4];
    // Blanking looks at the whole word, so a non-zero upper page keeps page 0 lit.
    zero_hi = ((snap_q >> {nib_sel, 2'b00}) == 32'd0);
    blank   = bus.blank_lz && (nib_sel != 3'd0) && zero_hi;
    // Decimal point on the leftmost digit marks the upper page, even when blanked.
    dp_n    = ~(page_q && (idx_q == 2'd3));
    seg     = seg7(nib);
    dig_d   = blank ? {7'h7F, dp_n} : {seg[7:1], dp_n};
    an_d    = ~(4'b1000 >> idx_q);
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      snap_q  <= '0;
      flags_q <= '0;
      slot_q  <= '0;
      idx_q   <= '0;
      page_q  <= 1'b0;
      frame_q <= '0;
      an_q    <= 4'b1111;
      dig_q   <= 8'hFF;
    end else begin
      snap_q  <= snap_d;
      flags_q <= flags_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      page_q  <= page_d;
      frame_q <= frame_d;
      an_q    <= an_d;
      dig_q   <= dig_d;
    end
  end

  assign bus.AN       = an_q;
  assign bus.dig      = dig_q;
  assign bus.LED      = flags_q;
  assign bus.page_out = page_q;

endmodule
